decode_stage: RTL and testbench

Pipelined instruction-decode stage for the RISC-V core: the successor to the single-cycle control/register-file/sign-extend/operand-mux cluster. It decodes an RV32I subset and reads a parametrised register file with write-back bypass. It resolves operand B and registers all results into an ID/EX pipeline register with valid, stall and flush control. It sits between the fetch stage and the execute stage; write-back drives its write port.

---
 rtl/decode_stage.sv | 216 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I-subset decode, bypassed register file and ID/EX pipeline register
module decode_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_valid,
    input  logic [31:0]               if_instr,
    input  logic [DATA_WIDTH-1:0]     if_pc,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [DATA_WIDTH-1:0]     ex_src_a,
    output logic [DATA_WIDTH-1:0]     ex_src_b,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs1,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs2,
    output logic [3:0]                ex_alu_control,
    output logic [1:0]                ex_result_src,
    output logic                      ex_mem_write,
    output logic                      ex_reg_write,
    output logic                      ex_branch,
    output logic                      ex_jump,
    output logic                      ex_illegal
);
    localparam int NREGS = 2 ** REG_ADDR_WIDTH;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    logic [DATA_WIDTH-1:0]     rf [NREGS];
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      funct7_5;
    logic [4:0]                rd_f, rs1_f, rs2_f;
    logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
    logic [DATA_WIDTH-1:0]     imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [DATA_WIDTH-1:0]     rs1_val, rs2_val, imm;
    logic [3:0]                alu_ctl;
    logic [1:0]                result_src;
    logic                      alu_src, reg_write, mem_write, branch, jump, illegal, lui;

    // funct3 picks the operation; alt (funct7[5]) only turns ADD into SUB and SRL into SRA
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // instruction fields, truncated to the register address width
    always_comb begin
        opcode   = if_instr[6:0];
        funct3   = if_instr[14:12];
        funct7_5 = if_instr[30];
        rd_f     = if_instr[11:7];
        rs1_f    = if_instr[19:15];
        rs2_f    = if_instr[24:20];
        rd       = rd_f[REG_ADDR_WIDTH-1:0];
        rs1      = rs1_f[REG_ADDR_WIDTH-1:0];
        rs2      = rs2_f[REG_ADDR_WIDTH-1:0];
    end

    // every immediate format, sign-extended from its top bit to the datapath width
    always_comb begin
        imm_i = DATA_WIDTH'($signed(if_instr[31:20]));
        imm_s = DATA_WIDTH'($signed({if_instr[31:25], if_instr[11:7]}));
        imm_b = DATA_WIDTH'($signed({if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0}));
        imm_j = DATA_WIDTH'($signed({if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0}));
        imm_u = DATA_WIDTH'($signed({if_instr[31:12], 12'b0}));
    end

    // main control decode; unknown opcodes flag illegal with every enable left low
    always_comb begin
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        illegal    = 1'b0;
        lui        = 1'b0;
        result_src = 2'd0;
        alu_ctl    = ALU_ADD;
        imm        = '0;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_ctl   = alu_fn(funct3, funct7_5);
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm       = imm_i;
                alu_ctl   = alu_fn(funct3, funct3 == 3'b101 && funct7_5);
            end
            OP_LD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'd1;
                imm        = imm_i;
            end
            OP_ST: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm       = imm_s;
            end
            OP_BR: begin
                branch  = 1'b1;
                alu_ctl = ALU_SUB;
                imm     = imm_b;
            end
            OP_JAL: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'd2;
                imm        = imm_j;
            end
            OP_LUI: begin
                lui       = 1'b1;
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm       = imm_u;
            end
            default: illegal = 1'b1;
        endcase
    end

    // read ports with write-through bypass so a same-cycle write-back is seen immediately
    always_comb begin
        rs1_val = rs1 == '0 ? '0 : (wb_we && wb_rd == rs1) ? wb_data : rf[rs1];
        rs2_val = rs2 == '0 ? '0 : (wb_we && wb_rd == rs2) ? wb_data : rf[rs2];
    end

    // register file write port; x0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        else if (wb_we && wb_rd != '0)
            rf[wb_rd] <= wb_data;
    end

    // ID/EX register: flush or an empty slot loads a bubble, stall holds, otherwise load decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            ex_src_a       <= '0;
            ex_src_b       <= '0;
            ex_store_data  <= '0;
            ex_imm         <= '0;
            ex_rd          <= '0;
            ex_rs1         <= '0;
            ex_rs2         <= '0;
            ex_alu_control <= '0;
            ex_result_src  <= '0;
            ex_mem_write   <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_branch      <= 1'b0;
            ex_jump        <= 1'b0;
            ex_illegal     <= 1'b0;
        end else if (flush || (!stall && !if_valid)) begin
            ex_valid     <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!stall) begin
            ex_valid       <= 1'b1;
            ex_pc          <= if_pc;
            ex_src_a       <= lui ? '0 : rs1_val;
            ex_src_b       <= alu_src ? imm : rs2_val;
            ex_store_data  <= rs2_val;
            ex_imm         <= imm;
            ex_rd          <= rd;
            ex_rs1         <= rs1;
            ex_rs2         <= rs2;
            ex_alu_control <= alu_ctl;
            ex_result_src  <= result_src;
            ex_mem_write   <= mem_write;
            ex_reg_write   <= reg_write;
            ex_branch      <= branch;
            ex_jump        <= jump;
            ex_illegal     <= illegal;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors checked against a spec-level decode model every cycle
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_src_a, ex_src_b, ex_store_data, ex_imm;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [3:0]  ex_alu_control;
    logic [1:0]  ex_result_src;
    logic        ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal;

    int checks = 0;
    int failures = 0;

    decode_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
        .ex_store_data(ex_store_data), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_alu_control(ex_alu_control), .ex_result_src(ex_result_src),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, a, b, sd, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  alu;
        logic [1:0]  rs;
        logic        mw, rw, br, jp, il, has_imm, alusrc, lui;
    } exp_t;

    exp_t        e;
    logic        e_valid;
    logic [31:0] m_rf [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? 32'(v - (1 << bits)) : 32'(v);
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] t [8];
        t = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd8;
        return t[f3];
    endfunction

    function automatic exp_t decode(input logic [31:0] ins);
        exp_t d;
        logic [2:0] f3;
        f3 = ins[14:12];
        d = '0;
        d.rd = ins[11:7];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        case (ins[6:0])
            7'h33: begin d.rw = 1; d.alu = alu_of(f3, ins[30]); end
            7'h13: begin d.rw = 1; d.alusrc = 1; d.has_imm = 1; d.imm = sext(int'(ins[31:20]), 12);
                         d.alu = alu_of(f3, f3 == 3'd5 && ins[30]); end
            7'h03: begin d.rw = 1; d.alusrc = 1; d.has_imm = 1; d.rs = 2'd1; d.imm = sext(int'(ins[31:20]), 12); end
            7'h23: begin d.mw = 1; d.alusrc = 1; d.has_imm = 1; d.imm = sext(int'({ins[31:25], ins[11:7]}), 12); end
            7'h63: begin d.br = 1; d.alu = 4'd1; d.has_imm = 1;
                         d.imm = sext(int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13); end
            7'h6F: begin d.jp = 1; d.rw = 1; d.rs = 2'd2; d.has_imm = 1;
                         d.imm = sext(int'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21); end
            7'h37: begin d.rw = 1; d.alusrc = 1; d.lui = 1; d.has_imm = 1; d.imm = {ins[31:12], 12'h000}; end
            default: d.il = 1;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] r);
        if (r == 0) return 0;
        if (wb_we && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    // reference model of the ID/EX contents after each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            e = '0;
            e_valid = 0;
        end else begin
            if (flush || (!stall && !if_valid)) begin
                e_valid = 0;
                e.mw = 0; e.rw = 0; e.br = 0; e.jp = 0; e.il = 0;
            end else if (!stall) begin
                exp_t d;
                d = decode(if_instr);
                d.pc = if_pc;
                d.a = d.lui ? 0 : rdreg(d.rs1);
                d.sd = rdreg(d.rs2);
                d.b = d.alusrc ? d.imm : d.sd;
                e = d;
                e_valid = 1;
            end
            if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
        end
    end

    // per-cycle comparison, on the falling edge away from the update edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 32'(ex_valid), 32'(e_valid));
            chk("ctrl", 32'({ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal}),
                32'({e.mw, e.rw, e.br, e.jp, e.il}));
            if (e_valid) begin
                chk("pc", ex_pc, e.pc);
                chk("src_a", ex_src_a, e.a);
                chk("src_b", ex_src_b, e.b);
                chk("store_data", ex_store_data, e.sd);
                chk("regs", 32'({ex_rd, ex_rs1, ex_rs2}), 32'({e.rd, e.rs1, e.rs2}));
                chk("result_src", 32'(ex_result_src), 32'(e.rs));
                if (!e.il) chk("alu", 32'(ex_alu_control), 32'(e.alu));
                if (e.has_imm) chk("imm", ex_imm, e.imm);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        wb_we = 0;
        if_valid = 1;
        if_instr = ins;
        if_pc = pc;
        step();
    endtask

    task automatic wb_only(input logic [4:0] r, input logic [31:0] v);
        if_valid = 0;
        wb_we = 1;
        wb_rd = r;
        wb_data = v;
        step();
        wb_we = 0;
    endtask

    logic [31:0] vec [14];

    initial begin
        vec = '{32'h402081B3, 32'h4030D193, 32'h0030D193, 32'h40008193, 32'h0020B1B3,
                32'h0040A183, 32'h008000EF, 32'h002091B3, 32'h0020C1B3, 32'h0020E1B3,
                32'h0020F1B3, 32'h0020A1B3, 32'h4020D1B3, 32'h00C0F193};
        #7;
        chk("reset_valid", 32'(ex_valid), 32'h0);
        chk("reset_pc", ex_pc, 32'h0);
        chk("reset_ctrl", 32'({ex_reg_write, ex_mem_write, ex_illegal}), 32'h0);
        #5 rst_n = 1;
        step();
        wb_only(5'd5, 32'h1234);
        issue(32'h000281B3, 32'h100);
        chk("add_src_a", ex_src_a, 32'h1234);
        chk("add_src_b", ex_src_b, 32'h0);
        chk("add_alu", 32'(ex_alu_control), 32'h0);
        chk("add_rw", 32'(ex_reg_write), 32'h1);
        chk("add_rd", 32'(ex_rd), 32'h3);
        if_valid = 1; if_instr = 32'hFFF38093; if_pc = 32'h104;
        wb_we = 1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
        step();
        wb_we = 0;
        chk("byp_src_a", ex_src_a, 32'hDEADBEEF);
        chk("byp_src_b", ex_src_b, 32'hFFFFFFFF);
        chk("byp_imm", ex_imm, 32'hFFFFFFFF);
        wb_only(5'd0, 32'hFFFF);
        issue(32'h00002423, 32'h108);
        chk("sw_store", ex_store_data, 32'h0);
        chk("sw_src_b", ex_src_b, 32'h8);
        chk("sw_mw_rw", 32'({ex_mem_write, ex_reg_write}), 32'h2);
        wb_only(5'd1, 32'h5);
        wb_only(5'd2, 32'h7);
        issue(32'hFE208EE3, 32'h10C);
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        chk("beq_br", 32'(ex_branch), 32'h1);
        chk("beq_alu", 32'(ex_alu_control), 32'h1);
        stall = 1;
        wb_we = 1; wb_rd = 5'd1; wb_data = 32'h99;
        step();
        wb_we = 0;
        step();
        step();
        chk("stall_imm", ex_imm, 32'hFFFFFFFC);
        chk("stall_src_a", ex_src_a, 32'h5);
        chk("stall_br_valid", 32'({ex_branch, ex_valid}), 32'h3);
        chk("stall_pc", ex_pc, 32'h10C);
        flush = 1;
        step();
        chk("flush_valid_br", 32'({ex_valid, ex_branch}), 32'h0);
        flush = 0; stall = 0;
        issue(32'h0000007F, 32'h110);
        chk("ill_flags", 32'({ex_illegal, ex_valid}), 32'h3);
        chk("ill_enables", 32'({ex_mem_write, ex_reg_write, ex_branch, ex_jump}), 32'h0);
        issue(32'h12345237, 32'h114);
        chk("lui_imm", ex_imm, 32'h12345000);
        chk("lui_src_a", ex_src_a, 32'h0);
        issue(32'h000301B3, 32'h118);
        stall = 1;
        wb_we = 1; wb_rd = 5'd6; wb_data = 32'hABCD;
        step();
        wb_we = 0;
        step();
        stall = 0;
        step();
        chk("stall_reread", ex_src_a, 32'hABCD);
        for (int i = 0; i < 14; i++) issue(vec[i], 32'h200 + 32'(i * 4));
        if_valid = 0;
        step();
        issue(32'h000281B3, 32'h300);
        chk("pre_rst_valid", 32'(ex_valid), 32'h1);
        #3 rst_n = 0;
        #2;
        chk("arst_valid", 32'(ex_valid), 32'h0);
        chk("arst_src_a", ex_src_a, 32'h0);
        chk("arst_pc", ex_pc, 32'h0);
        chk("arst_rw", 32'(ex_reg_write), 32'h0);
        #1 rst_n = 1;
        if_instr = 32'h000281B3; if_pc = 32'h304; if_valid = 1;
        step();
        chk("post_rst_x5", ex_src_a, 32'h0);
        chk("post_rst_valid", 32'(ex_valid), 32'h1);
        if_valid = 0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
